alu_arbiter: RTL

Shares the single-cycle RV32I ALU between two requesters: port 0 is the execute stage and port 1 is an auxiliary unit, such as CSR or debug address generation. The block arbitrates valid/ready requests into a one-entry issue register. It drives the shared ALU from that register and returns the ALU outputs to the owning requester through a valid/ready response channel. It sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter with a one-entry issue register in front of the shared RV32I ALU.
// Define ALU_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module alu_arbiter #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [XLEN-1:0]   i_req0_op1,
    input  logic [XLEN-1:0]   i_req0_op2,
    input  logic [XLEN-1:0]   i_req0_pc,
    input  logic [CTRL_W-1:0] i_req0_ctrl,

    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [XLEN-1:0]   i_req1_op1,
    input  logic [XLEN-1:0]   i_req1_op2,
    input  logic [XLEN-1:0]   i_req1_pc,
    input  logic [CTRL_W-1:0] i_req1_ctrl,

    output logic              o_rsp0_valid,
    input  logic              i_rsp0_ready,
    output logic              o_rsp1_valid,
    input  logic              i_rsp1_ready,

    output logic [XLEN-1:0]   o_rsp_result,
    output logic [XLEN-1:0]   o_rsp_jal_trgt,
    output logic [XLEN-1:0]   o_rsp_jalr_trgt,
    output logic              o_rsp_branch_taken,

    output logic [XLEN-1:0]   o_alu_op1,
    output logic [XLEN-1:0]   o_alu_op2,
    output logic [XLEN-1:0]   o_alu_pc,
    output logic [CTRL_W-1:0] o_alu_ctrl,
    input  logic [XLEN-1:0]   i_alu_result,
    input  logic [XLEN-1:0]   i_alu_jal_trgt,
    input  logic [XLEN-1:0]   i_alu_jalr_trgt,
    input  logic              i_alu_branch_taken,

    output logic              o_busy
);

    typedef enum logic [1:0] {EMPTY, OWN0, OWN1} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [XLEN-1:0]   r_pc;
    logic [CTRL_W-1:0] r_ctrl;

    logic w_tieTo1;
    logic w_grant0;
    logic w_grant1;
    logic w_slotFree;
    logic w_accept0;
    logic w_accept1;
    logic w_busy;

`ifdef ALU_ARB_RR_EN
    logic r_lastGrant;

    // Pointer starts at port 1 so that port 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= 1'b1;
        end else if (w_accept0) begin
            r_lastGrant <= 1'b0;
        end else if (w_accept1) begin
            r_lastGrant <= 1'b1;
        end
    end

    assign w_tieTo1 = ~r_lastGrant;
`else
    assign w_tieTo1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A slot frees up in the same cycle the owner consumes its response, giving 1 op/cycle.
    always_comb begin
        w_nextState  = r_state;
        o_rsp0_valid = (r_state == OWN0);
        o_rsp1_valid = (r_state == OWN1);
        w_busy       = (r_state != EMPTY);
        w_grant0     = i_req0_valid & (~i_req1_valid | ~w_tieTo1);
        w_grant1     = i_req1_valid & (~i_req0_valid | w_tieTo1);
        w_slotFree   = (r_state == EMPTY)
                     | (o_rsp0_valid & i_rsp0_ready)
                     | (o_rsp1_valid & i_rsp1_ready);
        w_accept0    = w_grant0 & w_slotFree;
        w_accept1    = w_grant1 & w_slotFree;
        o_req0_ready = w_accept0;
        o_req1_ready = w_accept1;
        if (w_accept0) begin
            w_nextState = OWN0;
        end else if (w_accept1) begin
            w_nextState = OWN1;
        end else if (w_slotFree) begin
            w_nextState = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1  <= '0;
            r_op2  <= '0;
            r_pc   <= '0;
            r_ctrl <= '0;
        end else if (w_accept0) begin
            r_op1  <= i_req0_op1;
            r_op2  <= i_req0_op2;
            r_pc   <= i_req0_pc;
            r_ctrl <= i_req0_ctrl;
        end else if (w_accept1) begin
            r_op1  <= i_req1_op1;
            r_op2  <= i_req1_op2;
            r_pc   <= i_req1_pc;
            r_ctrl <= i_req1_ctrl;
        end
    end

    // An empty slot presents ADD 0+0 so the ALU inputs never show stale operands.
    assign o_alu_op1  = w_busy ? r_op1  : '0;
    assign o_alu_op2  = w_busy ? r_op2  : '0;
    assign o_alu_pc   = w_busy ? r_pc   : '0;
    assign o_alu_ctrl = w_busy ? r_ctrl : '0;

    assign o_rsp_result       = i_alu_result;
    assign o_rsp_jal_trgt     = i_alu_jal_trgt;
    assign o_rsp_jalr_trgt    = i_alu_jalr_trgt;
    assign o_rsp_branch_taken = i_alu_branch_taken;
    assign o_busy             = w_busy;

endmodule
